n_1_mux: RTL and testbench

- Parameterizable N-to-1 multiplexer. Default configuration is 16:1, 1-bit data.
- Provides three outputs:
  - a combinational selected output;
  - a registered copy of the selected output, one clock of latency;
  - a one-hot decode of the select.
- Used as a generic bit/word selector in datapaths. The registered output serves timing-critical consumers.

---
 rtl/n_1_mux.sv | 95 +++++++++
 tb/tb_n_1_mux.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/n_1_mux.sv
`default_nettype none
// ============================================================================
//  Module   : n_1_mux
//  Purpose  : Parameterizable N-to-1 multiplexer. It has a combinational
//             selected output, a registered copy with one cycle of latency,
//             and a one-hot decode of the select.
//  Options  : N_1_MUX_HOLD_EN adds a 'hold' input. When hold is high, y_q
//             keeps its value (rst has priority over hold).
//  Revision : 1.0 - initial release
// ============================================================================
module n_1_mux #(
  parameter int N_IN  = 16,
  parameter int DW    = 1,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef N_1_MUX_HOLD_EN
  input  logic                 hold,
`endif
  input  logic [N_IN*DW-1:0]   in,
  input  logic [SEL_W-1:0]     sel,
  output logic [DW-1:0]        y,
  output logic [DW-1:0]        y_q,
  output logic [N_IN-1:0]      sel_oh
);

  // Number of inputs expressed one bit wider than sel. The range check
  // therefore works without truncation, including when N_IN is a power of 2.
  localparam logic [SEL_W:0] c_n_in = (SEL_W + 1)'(N_IN);

  // Unpacked view of the packed input bus. Input k sits at [k*DW +: DW].
  logic [DW-1:0] w_in_arr [N_IN];

  // High when sel addresses an existing input. This can only be low when
  // N_IN is not a power of 2.
  logic w_sel_valid;

  // Registered copy of the selected data.
  logic [DW-1:0] r_y_q;

  // Slice the packed bus into the per-input array.
  generate
    for (genvar k = 0; k < N_IN; k++) begin : g_unpack
      assign w_in_arr[k] = in[k*DW +: DW];
    end
  endgenerate

  // Range check of the select against the number of inputs.
  always_comb begin
    w_sel_valid = ({1'b0, sel} < c_n_in);
  end

  // Direct index select. An out-of-range select yields zero.
  always_comb begin
    y = '0;
    if (w_sel_valid) begin
      y = w_in_arr[sel];
    end
  end

  // One-hot decode. No bit matches an out-of-range select, so the result is all zeros.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_oh[k] = 1'b1;
      end
    end
  end

`ifdef N_1_MUX_HOLD_EN
  // Output register: reset clears it, hold freezes it, otherwise it follows y.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q <= '0;
    end else if (!hold) begin
      r_y_q <= y;
    end
  end
`else
  // Output register: reset clears it, otherwise it follows y every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= y;
    end
  end
`endif

  assign y_q = r_y_q;

endmodule
`default_nettype wire

// File: tb/tb_n_1_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n_1_mux
//  Purpose  : Self-checking bench for n_1_mux in its default 16:1 x 1-bit
//             configuration. It uses a table of directed vectors, then
//             hand-written sequences for reset and the registered path.
//             The hold sequences are compiled in with N_1_MUX_HOLD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_n_1_mux;

  localparam int N_IN  = 16;
  localparam int DW    = 1;
  localparam int SEL_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic [N_IN-1:0]   in;
  logic [SEL_W-1:0]  sel;
  logic [DW-1:0]     y;
  logic [DW-1:0]     y_q;
  logic [N_IN-1:0]   sel_oh;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] vin;
    logic [3:0]  vsel;
    logic        exp_y;
    logic [15:0] exp_oh;
  } vec_t;

  vec_t vecs [10];

  n_1_mux #(.N_IN(N_IN), .DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef N_1_MUX_HOLD_EN
    .hold   (hold),
`endif
    .in     (in),
    .sel    (sel),
    .y      (y),
    .y_q    (y_q),
    .sel_oh (sel_oh)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and are checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_y;

    vecs[0] = '{16'h8000, 4'd0,  1'b0, 16'h0001};
    vecs[1] = '{16'h8001, 4'd15, 1'b1, 16'h8000};
    vecs[2] = '{16'h4002, 4'd1,  1'b1, 16'h0002};
    vecs[3] = '{16'h2004, 4'd2,  1'b1, 16'h0004};
    vecs[4] = '{16'h1000, 4'd3,  1'b0, 16'h0008};
    vecs[5] = '{16'h0400, 4'd5,  1'b0, 16'h0020};
    vecs[6] = '{16'h01E0, 4'd7,  1'b1, 16'h0080};
    vecs[7] = '{16'h0620, 4'd10, 1'b1, 16'h0400};
    vecs[8] = '{16'h0010, 4'd11, 1'b0, 16'h0800};
    vecs[9] = '{16'h0008, 4'd12, 1'b0, 16'h1000};

    // Reset held for two edges. y keeps tracking the inputs while y_q stays cleared.
    rst  = 1'b1;
    hold = 1'b0;
    in   = 16'hFFFF;
    sel  = 4'd0;
    step();
    step();
    chk("reset_y_q", 32'(y_q), 32'h0);
    chk("reset_y_tracks", 32'(y), 32'h1);

    // Directed table. y_q is checked one edge later against the previous y.
    rst    = 1'b0;
    prev_y = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in  = vecs[i].vin;
      sel = vecs[i].vsel;
      #1;
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
      chk($sformatf("vec%0d_oh", i), 32'(sel_oh), 32'(vecs[i].exp_oh));
      step();
      chk($sformatf("vec%0d_y_q", i), 32'(y_q), 32'(vecs[i].exp_y));
      prev_y = vecs[i].exp_y;
    end
    chk("table_last_y_q", 32'(y_q), 32'(prev_y));

    // Registered path: y follows immediately, and y_q follows one edge later.
    in  = 16'h0080;
    sel = 4'd7;
    #1;
    chk("reg_y_imm_1", 32'(y), 32'h1);
    chk("reg_y_q_before", 32'(y_q), 32'h0);
    step();
    chk("reg_y_q_1", 32'(y_q), 32'h1);
    sel = 4'd8;
    #1;
    chk("reg_y_imm_0", 32'(y), 32'h0);
    chk("reg_y_q_still_1", 32'(y_q), 32'h1);
    step();
    chk("reg_y_q_0", 32'(y_q), 32'h0);

    // Reset mid-operation.
    sel = 4'd7;
    step();
    chk("mid_y_q_set", 32'(y_q), 32'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_y_q", 32'(y_q), 32'h0);
    chk("mid_rst_y", 32'(y), 32'h1);
    rst = 1'b0;
    step();
    chk("mid_release_y_q", 32'(y_q), 32'h1);

`ifdef N_1_MUX_HOLD_EN
    // With hold high, y_q freezes even though y has changed.
    hold = 1'b1;
    sel  = 4'd8;
    step();
    chk("hold_y", 32'(y), 32'h0);
    chk("hold_y_q", 32'(y_q), 32'h1);
    step();
    chk("hold_y_q_2", 32'(y_q), 32'h1);
    // Reset overrides hold.
    rst = 1'b1;
    step();
    chk("hold_rst_y_q", 32'(y_q), 32'h0);
    // With hold released, y_q tracks y again.
    rst  = 1'b0;
    hold = 1'b0;
    sel  = 4'd7;
    step();
    chk("unhold_y_q", 32'(y_q), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
